// File: rtl/icache_direct.sv
// Direct-mapped, read-only, one-word-per-frame instruction cache between the
// fetch stage and the memory controller; one outstanding fill at a time.
module icache_direct #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t          state;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tag_mem  [SETS];
  logic [31:0]     data_mem [SETS];
  logic [31:0]     fill_addr;

  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   req_tag;
  logic [IW-1:0]   fill_idx;
  logic [TW-1:0]   fill_tag;
  logic            lookup_hit;
  logic            idle_hit;
  logic            idle_miss;
  logic            fill_done;
  logic            fwd;
  logic            unused_addr_lsb;

  assign req_idx  = imemaddr[IW+1:2];
  assign req_tag  = imemaddr[31:IW+2];
  assign fill_idx = fill_addr[IW+1:2];
  assign fill_tag = fill_addr[31:IW+2];
  assign unused_addr_lsb = ^imemaddr[1:0];

  // A flush in IDLE hides the frame being looked up, so that request refetches.
  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign idle_hit   = (state == IDLE) && imemREN && lookup_hit && !flush;
  assign idle_miss  = (state == IDLE) && imemREN && !(lookup_hit && !flush);
  assign fill_done  = (state == FETCH) && !iwait;
  assign fwd        = fill_done && imemREN && (imemaddr[31:2] == fill_addr[31:2]);

  always_comb begin
    ihit     = !RST && (idle_hit || fwd);
    imemload = fwd ? iload : data_mem[req_idx];
  end

  assign iREN  = (state == FETCH);
  assign iaddr = fill_addr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      valid      <= '0;
      fill_addr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) valid <= '0;
          if (idle_hit) hit_count <= hit_count + 32'd1;
          if (idle_miss) begin
            fill_addr  <= {imemaddr[31:2], 2'b00};
            miss_count <= miss_count + 32'd1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          // The in-flight fill survives a flush: clear first, then mark its frame.
          if (flush) valid <= '0;
          if (!iwait) begin
            valid[fill_idx] <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && fill_done) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios followed by random
// fetches, checked against a word-level model of the cache contents.
module tb_icache_direct;
  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_direct #(.SETS(SETS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .flush     (flush),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: which word address each frame holds, and its data.
  logic        m_valid [SETS];
  logic [31:0] m_word  [SETS];
  logic [31:0] m_data  [SETS];
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (w == 32'h40) return 32'h2001_0005;
    return (w * 32'h0100_0193) ^ 32'hC0DE_0000;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic m_clear();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
  endtask

  task automatic m_fill(input logic [31:0] a);
    int i;
    i = idx_of(a);
    m_valid[i] = 1'b1;
    m_word[i]  = a >> 2;
    m_data[i]  = mem_val(a);
  endtask

  task automatic do_reset();
    RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b0; flush = 1'b0; iload = 32'h0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("rst_ihit", ihit, 1'b0);
      chk("rst_iren", iREN, 1'b0);
      cyc();
    end
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_hits", hit_count, 32'h0);
    chk("rst_misses", miss_count, 32'h0);
    RST = 1'b0; imemREN = 1'b0;
    m_clear(); m_hits = 0; m_misses = 0;
  endtask

  // One fetch, held until served; flush_at selects a FETCH cycle to flush in (-1: none).
  task automatic do_fetch(input logic [31:0] addr, input int nwait, input int flush_at);
    int   i;
    logic exp_hit;
    i = idx_of(addr);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1; flush = 1'b0; iload = $urandom;
    exp_hit = m_valid[i] && (m_word[i] == (addr >> 2));
    @(negedge CLK);
    chk("lookup_ihit", ihit, exp_hit);
    chk("lookup_iren", iREN, 1'b0);
    if (exp_hit) chk("hit_data", imemload, m_data[i]);
    cyc();
    if (exp_hit) m_hits++;
    else begin
      m_misses++;
      for (int w = 0; w <= nwait; w++) begin
        iwait = (w < nwait);
        flush = (w == flush_at);
        iload = (w == nwait) ? mem_val(addr) : $urandom;
        @(negedge CLK);
        chk("fetch_iren", iREN, 1'b1);
        chk("fetch_iaddr", iaddr, addr & ~32'h3);
        chk("fetch_ihit", ihit, (w == nwait));
        if (w == nwait) chk("fwd_data", imemload, mem_val(addr));
        if (w == flush_at) m_clear();
        cyc();
      end
      flush = 1'b0;
      m_fill(addr);
    end
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
  endtask

  task automatic idle_flush();
    imemREN = 1'b0; flush = 1'b1;
    @(negedge CLK);
    chk("iflush_ihit", ihit, 1'b0);
    cyc();
    flush = 1'b0;
    m_clear();
  endtask

  initial begin
    logic [31:0] a;
    int          nw;
    int          fa;
    int          r;

    // Reset held with a request pending; first request afterwards misses.
    do_reset();
    do_fetch(32'h0, 0, -1);
    chk("rst_first_miss", miss_count, 32'd1);

    // Cold miss with two wait cycles, then a zero-latency re-hit.
    do_fetch(32'h40, 2, -1);
    do_fetch(32'h40, 0, -1);
    chk("cold_rehit_count", hit_count, 32'd1);

    // Conflict on index 0.
    do_reset();
    do_fetch(32'h00, 0, -1);
    do_fetch(32'h40, 0, -1);
    do_fetch(32'h00, 0, -1);
    chk("conflict_misses", miss_count, 32'd3);

    // Redirect while the fill for 0x80 is waiting.
    do_reset();
    imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1;
    @(negedge CLK); chk("rd_miss_ihit", ihit, 1'b0);
    cyc(); m_misses++;
    imemaddr = 32'h84;
    @(negedge CLK); chk("rd_wait_ihit", ihit, 1'b0); chk("rd_wait_iaddr", iaddr, 32'h80);
    cyc();
    iwait = 1'b0; iload = mem_val(32'h80);
    @(negedge CLK); chk("rd_done_ihit", ihit, 1'b0); chk("rd_done_iren", iREN, 1'b1);
    cyc(); m_fill(32'h80);
    @(negedge CLK); chk("rd_84_ihit", ihit, 1'b0); chk("rd_84_iren", iREN, 1'b0);
    cyc(); m_misses++;
    iload = mem_val(32'h84);
    @(negedge CLK); chk("rd_84_fwd", ihit, 1'b1); chk("rd_84_data", imemload, mem_val(32'h84));
    cyc(); m_fill(32'h84);
    chk("rd_misses", miss_count, 32'd2);
    do_fetch(32'h80, 0, -1);
    chk("rd_80_hits", hit_count, 32'd1);

    // Flush in IDLE, then flush during a fill.
    do_reset();
    do_fetch(32'h10, 0, -1);
    do_fetch(32'h14, 0, -1);
    idle_flush();
    do_fetch(32'h10, 0, -1);
    chk("flush_idle_misses", miss_count, 32'd3);
    do_fetch(32'h20, 1, 0);
    do_fetch(32'h20, 0, -1);
    do_fetch(32'h10, 0, -1);
    chk("flush_fetch_misses", miss_count, 32'd5);
    chk("flush_fetch_hits", hit_count, 32'd1);

    // Reset during a fill abandons it.
    do_reset();
    imemREN = 1'b1; imemaddr = 32'h30; iwait = 1'b1;
    cyc(); cyc();
    RST = 1'b1; iwait = 1'b0; iload = mem_val(32'h30);
    @(negedge CLK); chk("rstf_ihit", ihit, 1'b0);
    cyc();
    chk("rstf_iren", iREN, 1'b0);
    RST = 1'b0; m_clear(); m_hits = 0; m_misses = 0;
    do_fetch(32'h30, 0, -1);

    // Sequential stream, twice.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 8; k++) do_fetch(32'(k * 4), 0, -1);
    chk("stream_hits", hit_count, 32'd8);
    chk("stream_misses", miss_count, 32'd8);

    // Random traffic over a small address pool to force conflicts.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) idle_flush();
      else if (r == 1) begin
        imemREN = 1'b0; imemaddr = $urandom;
        @(negedge CLK);
        chk("idle_ihit", ihit, 1'b0);
        chk("idle_iren", iREN, 1'b0);
        cyc();
      end else begin
        a  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        nw = $urandom_range(0, 3);
        fa = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nw) : -1;
        do_fetch(a, nw, fa);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
